bp_l15_responder_stub: RTL and testbench
========================================

BP_L15_RESPONDER_STUB -- requirements
Module: bp_l15_responder_stub

Interface
REQ-001 SHALL have parameter mem_lines_p, default 256: number of 16-byte lines in backing store (power of two).
REQ-002 SHALL have parameter wake_delay_p, default 16: cycles after reset release before the wake-up interrupt.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port reset_n_i, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports transducer_l15_val/rqtype/nc/size/address/data/l1rplway, inputs, widths 1/5/1/3/40/64/2: the request channel.
REQ-006 SHALL have ports l15_transducer_ack and l15_transducer_header_ack, outputs, 1 each: request accepted.
REQ-007 SHALL have ports l15_transducer_val, l15_transducer_returntype and l15_transducer_data_0/_1, outputs, widths 1/4/64/64: the response channel.
REQ-008 SHALL have port transducer_l15_req_ack, input, 1: the response is consumed.
REQ-009 SHALL have port error_o, output, 1: sticky protocol-error flag.

Function
REQ-010 SHALL implement the FSM states e_wait, e_wake, e_idle, e_access and e_resp.
REQ-011 e_wait SHALL count wake_delay_p cycles, then go to e_wake.
REQ-012 e_wake SHALL assert l15_transducer_val with returntype INT_RET and data zero, holding it until transducer_l15_req_ack, then go to e_idle.
REQ-013 In e_idle, if transducer_l15_val=1, SHALL assert l15_transducer_ack and header_ack combinationally in that cycle, latch rqtype/size/address/data, and go to e_access.
REQ-014 ack SHALL never be asserted outside e_idle.
REQ-015 Line index SHALL be address[4 +: log2(mem_lines_p)]; upper address bits are ignored (aliasing wraps).
REQ-016 Byte lanes: line byte offset o (0-15) SHALL map to data_0 when o<8 and data_1 otherwise, at bits [63-8*(o%8) -: 8] (big-endian within the doubleword).
REQ-017 For LOAD_RQ, e_access SHALL issue a synchronous read of the full line; response data_0/data_1 = the line, regardless of size or nc.
REQ-018 For STORE_RQ of size 1B/2B/4B/8B, e_access SHALL write bytes o..o+size-1 (o = address[3:0]), taking each byte from the lane of transducer_l15_data that REQ-016 assigns to that byte.
REQ-019 A store whose address is not aligned to its size, or that has size 16B, SHALL be dropped, set error_o, and still be answered with ST_ACK.
REQ-020 Any other rqtype SHALL set error_o and be answered with ST_ACK and zero data.
REQ-021 e_resp SHALL assert l15_transducer_val with LOAD_RET (for loads) or ST_ACK (otherwise).
REQ-022 Data SHALL be held stable while val=1; on req_ack the FSM SHALL go to e_idle.
REQ-023 Latency from the request-ack cycle to the first response-val cycle SHALL be exactly 2 cycles.
REQ-024 A load following a store to the same line SHALL return the stored bytes.
REQ-025 req_ack while val=0 SHALL set error_o and be otherwise ignored.
REQ-026 At most one request SHALL be outstanding; a new request is not acked until the previous response is consumed.

Reset
REQ-027 With reset_n_i=0 at a clock edge, the FSM SHALL go to e_wait, the counter and error_o SHALL clear, and all outputs SHALL be 0.
REQ-028 A reset mid-transaction SHALL abandon the request with no response.
REQ-029 Memory contents SHALL NOT be cleared by reset, and a store in e_access during the reset cycle SHALL NOT be written.

Structure
REQ-030 rqtype, returntype and PCX size codes SHALL come from the shared L1.5 define headers; the state enum SHALL stay local.
REQ-031 Backing store SHALL be one sub-module, bsg_mem_1rw_sync_mask_write_byte, width 128, els mem_lines_p.

Verification
REQ-032 Release reset and hold req_ack=0 -> val rises at cycle 16 with INT_RET and stays high; req_ack=1 -> val drops next cycle.
REQ-033 Store 8B 0x0011223344556677 to 0x1008, then LOAD_RQ 0x1000 -> data_1=0x0011223344556677, data_0 unchanged, LOAD_RET two cycles after ack.
REQ-034 Store 1B 0xAB to 0x1003 -> later load: data_0 bits [39:32]=0xAB, all other bytes unchanged.
REQ-035 Store 4B to 0x1002 (misaligned) -> ST_ACK, error_o=1, memory unchanged.
REQ-036 Load 0x0 and 0x1000 with mem_lines_p=256 -> identical data (wrap).
REQ-037 Assert reset during e_resp of a load -> val=0 next cycle, INT_RET re-sent after 16 cycles, prior memory contents intact.

Source files
------------

// File: rtl/bp_l15_responder_stub_pkg.sv
// L1.5 responder stub: shared request/return/size codes.
// Codes match the OpenPiton L1.5 transducer encodings.
package bp_l15_responder_stub_pkg;

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    localparam logic [3:0] LOAD_RET = 4'b0000;
    localparam logic [3:0] ST_ACK   = 4'b0100;
    localparam logic [3:0] INT_RET  = 4'b0111;

    localparam logic [2:0] PCX_SZ_1B  = 3'b000;
    localparam logic [2:0] PCX_SZ_2B  = 3'b001;
    localparam logic [2:0] PCX_SZ_4B  = 3'b010;
    localparam logic [2:0] PCX_SZ_8B  = 3'b011;
    localparam logic [2:0] PCX_SZ_16B = 3'b111;

    // Storage byte lane (line bits [8*lane +: 8]) to line byte offset.
    // Big-endian within each doubleword, dword 0 in line[63:0].
    function automatic logic [3:0] lane_byte(input logic [3:0] lane);
        return {lane[3], ~lane[2:0]};
    endfunction

endpackage

// File: rtl/bp_l15_responder_stub_if.sv
// L1.5 transducer request/response bundle.
// master: transducer side (drives requests, consumes responses);
// slave: responder side (acks requests, drives responses).
interface bp_l15_responder_stub_if;

    logic        transducer_l15_val;
    logic [4:0]  transducer_l15_rqtype;
    logic        transducer_l15_nc;
    logic [2:0]  transducer_l15_size;
    logic [39:0] transducer_l15_address;
    logic [63:0] transducer_l15_data;
    logic [1:0]  transducer_l15_l1rplway;
    logic        l15_transducer_ack;
    logic        l15_transducer_header_ack;

    logic        l15_transducer_val;
    logic [3:0]  l15_transducer_returntype;
    logic [63:0] l15_transducer_data_0;
    logic [63:0] l15_transducer_data_1;
    logic        transducer_l15_req_ack;

    modport master (
        output transducer_l15_val, transducer_l15_rqtype,
               transducer_l15_nc, transducer_l15_size,
               transducer_l15_address, transducer_l15_data,
               transducer_l15_l1rplway, transducer_l15_req_ack,
        input  l15_transducer_ack, l15_transducer_header_ack,
               l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0, l15_transducer_data_1
    );

    modport slave (
        input  transducer_l15_val, transducer_l15_rqtype,
               transducer_l15_nc, transducer_l15_size,
               transducer_l15_address, transducer_l15_data,
               transducer_l15_l1rplway, transducer_l15_req_ack,
        output l15_transducer_ack, l15_transducer_header_ack,
               l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0, l15_transducer_data_1
    );

endinterface

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Single-port synchronous RAM with byte write mask; not reset.
// Ports: clk_i, v_i/w_i access strobes, addr_i, data_i, write_mask_i, data_o.
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int width_p = 128,
    parameter int els_p   = 256
) (
    input  logic                       clk_i,
    input  logic                       v_i,
    input  logic                       w_i,
    input  logic [$clog2(els_p)-1:0]   addr_i,
    input  logic [width_p-1:0]         data_i,
    input  logic [width_p/8-1:0]       write_mask_i,
    output logic [width_p-1:0]         data_o
);

    logic [width_p-1:0] mem [els_p];

    // data_o only changes on a read, so it holds between accesses.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            for (int b = 0; b < width_p/8; b++) begin
                if (write_mask_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
        if (v_i && !w_i) begin
            data_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/bp_l15_responder_stub.sv
// L1.5 responder stub: wake-up interrupt, then one-at-a-time load/store to a line RAM.
// Ports: clk_i, reset_n_i (sync, active low), l15 (slave bundle), error_o (sticky).
module bp_l15_responder_stub
    import bp_l15_responder_stub_pkg::*;
#(
    parameter int mem_lines_p  = 256,
    parameter int wake_delay_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_l15_responder_stub_if.slave  l15,
    output logic                    error_o
);

    localparam int idx_w = $clog2(mem_lines_p);
    localparam int cnt_w = (wake_delay_p > 1) ? $clog2(wake_delay_p) : 1;

    typedef enum logic [2:0] {
        e_wait, e_wake, e_idle, e_access, e_resp
    } state_e;

    state_e state, state_n;

    logic [cnt_w-1:0] cnt;
    logic [4:0]       rq_r;
    logic [2:0]       size_r;
    logic [idx_w-1:0] idx_r;
    logic [3:0]       off_r;
    logic [63:0]      data_r;

    logic        wake_done, is_load, is_store, aligned, store_ok;
    logic [15:0] byte_mask, lane_mask;
    logic        mem_v, mem_w;
    logic [127:0] mem_rdata;
    logic        unused_ok;

    assign wake_done = (cnt == cnt_w'(wake_delay_p - 1));
    assign unused_ok = ^{l15.transducer_l15_nc, l15.transducer_l15_l1rplway,
                         l15.transducer_l15_address[39:4+idx_w]};

    always_comb begin
        is_load   = (rq_r == LOAD_RQ);
        is_store  = (rq_r == STORE_RQ);
        aligned   = 1'b0;
        byte_mask = '0;
        unique case (1'b1)
            size_r == PCX_SZ_1B: begin
                aligned   = 1'b1;
                byte_mask = 16'h0001 << off_r;
            end
            size_r == PCX_SZ_2B: begin
                aligned   = (off_r[0] == 1'b0);
                byte_mask = 16'h0003 << off_r;
            end
            size_r == PCX_SZ_4B: begin
                aligned   = (off_r[1:0] == 2'b00);
                byte_mask = 16'h000f << off_r;
            end
            size_r == PCX_SZ_8B: begin
                aligned   = (off_r[2:0] == 3'b000);
                byte_mask = 16'h00ff << off_r;
            end
            default: ;
        endcase
        store_ok = is_store && aligned;
        for (int k = 0; k < 16; k++) begin
            lane_mask[k] = store_ok & byte_mask[lane_byte(4'(k))];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state <= e_wait;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            e_wait:   if (wake_done) state_n = e_wake;
            e_wake:   if (l15.transducer_l15_req_ack) state_n = e_idle;
            e_idle:   if (l15.transducer_l15_val) state_n = e_access;
            e_access: state_n = e_resp;
            e_resp:   if (l15.transducer_l15_req_ack) state_n = e_idle;
            default:  state_n = e_wait;
        endcase
    end

    // Outputs are forced low in a reset cycle; the RAM strobe too,
    // so a store caught by reset never lands.
    always_comb begin
        l15.l15_transducer_ack        = 1'b0;
        l15.l15_transducer_header_ack = 1'b0;
        l15.l15_transducer_val        = 1'b0;
        l15.l15_transducer_returntype = '0;
        l15.l15_transducer_data_0     = '0;
        l15.l15_transducer_data_1     = '0;
        mem_v = 1'b0;
        mem_w = 1'b0;
        if (reset_n_i) begin
            unique case (state)
                e_wake: begin
                    l15.l15_transducer_val        = 1'b1;
                    l15.l15_transducer_returntype = INT_RET;
                end
                e_idle: begin
                    l15.l15_transducer_ack        = l15.transducer_l15_val;
                    l15.l15_transducer_header_ack = l15.transducer_l15_val;
                end
                e_access: begin
                    mem_v = is_load | store_ok;
                    mem_w = store_ok;
                end
                e_resp: begin
                    l15.l15_transducer_val        = 1'b1;
                    l15.l15_transducer_returntype = is_load ? LOAD_RET : ST_ACK;
                    if (is_load) begin
                        {l15.l15_transducer_data_1,
                         l15.l15_transducer_data_0} = mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cnt     <= '0;
            error_o <= 1'b0;
        end else begin
            if (state == e_wait && !wake_done) begin
                cnt <= cnt + 1'b1;
            end
            if (state == e_access && !(is_load || store_ok)) begin
                error_o <= 1'b1;
            end
            if (l15.transducer_l15_req_ack && !l15.l15_transducer_val) begin
                error_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == e_idle && l15.transducer_l15_val) begin
            rq_r   <= l15.transducer_l15_rqtype;
            size_r <= l15.transducer_l15_size;
            idx_r  <= l15.transducer_l15_address[4 +: idx_w];
            off_r  <= l15.transducer_l15_address[3:0];
            data_r <= l15.transducer_l15_data;
        end
    end

    // Both dwords of the write line carry the request data; the
    // lane mask picks which bytes land.
    bsg_mem_1rw_sync_mask_write_byte #(
        .width_p (128),
        .els_p   (mem_lines_p)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (mem_v),
        .w_i          (mem_w),
        .addr_i       (idx_r),
        .data_i       ({data_r, data_r}),
        .write_mask_i (lane_mask),
        .data_o       (mem_rdata)
    );

endmodule

// File: tb/tb_bp_l15_responder_stub.sv
// Self-checking bench for bp_l15_responder_stub.
// Table of directed requests plus hand sequences for reset and protocol corners.
module tb_bp_l15_responder_stub;

    localparam logic [4:0] LD = 5'b00000;
    localparam logic [4:0] ST = 5'b00001;
    localparam logic [4:0] OT = 5'b00100;
    localparam logic [2:0] S1 = 3'b000;
    localparam logic [2:0] S2 = 3'b001;
    localparam logic [2:0] S4 = 3'b010;
    localparam logic [2:0] S8 = 3'b011;
    localparam logic [2:0] S16 = 3'b111;
    localparam logic [3:0] R_LD = 4'h0;
    localparam logic [3:0] R_ST = 4'h4;
    localparam logic [3:0] R_INT = 4'h7;

    localparam logic [63:0] A  = 64'h8877665544332211;
    localparam logic [63:0] A1 = 64'h887766AB44332211;
    localparam logic [63:0] B  = 64'hFFEEDDCCBBAA9988;
    localparam logic [63:0] C  = 64'h0123456789ABCDEF;
    localparam logic [63:0] D  = 64'hFEDCBA9876543210;
    localparam logic [63:0] E  = 64'h0011223344556677;
    localparam logic [63:0] F  = 64'h0011C0DECAFEF00D;

    typedef struct {
        logic [4:0]  rq;
        logic [2:0]  sz;
        logic [39:0] a;
        logic [63:0] d;
        logic [3:0]  rt;
        logic        chk;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        err;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    logic clk = 1'b0;
    logic reset_n;
    logic error;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bp_l15_responder_stub_if l15();

    bp_l15_responder_stub #(
        .mem_lines_p  (256),
        .wake_delay_p (16)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .l15       (l15),
        .error_o   (error)
    );

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wake();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!l15.l15_transducer_val && n < 100);
        check("wake_cycle", 128'(n), 128'(16));
        check("wake_rt", 128'(l15.l15_transducer_returntype), 128'(R_INT));
        check("wake_data", {l15.l15_transducer_data_1,
                            l15.l15_transducer_data_0}, 128'(0));
        repeat (3) @(posedge clk);
        #1;
        check("wake_hold", 128'(l15.l15_transducer_val), 128'(1));
        l15.transducer_l15_req_ack = 1'b1;
        @(posedge clk);
        #1;
        l15.transducer_l15_req_ack = 1'b0;
        check("wake_drop", 128'(l15.l15_transducer_val), 128'(0));
    endtask

    task automatic send(input logic [4:0] rq, input logic [2:0] sz,
                        input logic [39:0] a, input logic [63:0] d);
        int n = 0;
        @(negedge clk);
        l15.transducer_l15_val     = 1'b1;
        l15.transducer_l15_rqtype  = rq;
        l15.transducer_l15_size    = sz;
        l15.transducer_l15_address = a;
        l15.transducer_l15_data    = d;
        #1;
        while (!l15.l15_transducer_ack && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ack", 128'(l15.l15_transducer_ack), 128'(1));
        check("hdr_ack", 128'(l15.l15_transducer_header_ack), 128'(1));
        @(posedge clk);
        #1;
        l15.transducer_l15_val = 1'b0;
    endtask

    // Called right after send: one cycle past the ack cycle.
    task automatic wait_resp(output int lat);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!l15.l15_transducer_val && n < 20);
        lat = n + 1;
    endtask

    task automatic consume();
        l15.transducer_l15_req_ack = 1'b1;
        @(posedge clk);
        #1;
        l15.transducer_l15_req_ack = 1'b0;
        check("val_drop", 128'(l15.l15_transducer_val), 128'(0));
    endtask

    initial begin
        int lat;

        tbl[0]  = '{ST, S8, 40'h1000, A, R_ST, 1'b0, 64'h0, 64'h0, 1'b0};
        tbl[1]  = '{ST, S8, 40'h1008, B, R_ST, 1'b0, 64'h0, 64'h0, 1'b0};
        tbl[2]  = '{ST, S8, 40'h0018, D, R_ST, 1'b0, 64'h0, 64'h0, 1'b0};
        tbl[3]  = '{ST, S8, 40'h2010, C, R_ST, 1'b0, 64'h0, 64'h0, 1'b0};
        tbl[4]  = '{LD, S8, 40'h1000, 64'h0, R_LD, 1'b1, A, B, 1'b0};
        tbl[5]  = '{ST, S8, 40'h1008, E, R_ST, 1'b0, 64'h0, 64'h0, 1'b0};
        tbl[6]  = '{LD, S1, 40'h1000, 64'h0, R_LD, 1'b1, A, E, 1'b0};
        tbl[7]  = '{ST, S1, 40'h1003, 64'h000000AB00000000, R_ST, 1'b0,
                    64'h0, 64'h0, 1'b0};
        tbl[8]  = '{LD, S4, 40'h1000, 64'h0, R_LD, 1'b1, A1, E, 1'b0};
        tbl[9]  = '{ST, S2, 40'h100A, 64'h0000C0DE00000000, R_ST, 1'b0,
                    64'h0, 64'h0, 1'b0};
        tbl[10] = '{ST, S4, 40'h100C, 64'h00000000CAFEF00D, R_ST, 1'b0,
                    64'h0, 64'h0, 1'b0};
        tbl[11] = '{LD, S8, 40'h0000, 64'h0, R_LD, 1'b1, A1, F, 1'b0};
        tbl[12] = '{LD, S8, 40'h1000, 64'h0, R_LD, 1'b1, A1, F, 1'b0};
        tbl[13] = '{LD, S8, 40'h0010, 64'h0, R_LD, 1'b1, C, D, 1'b0};
        tbl[14] = '{ST, S4, 40'h1002, 64'hFFFFFFFFFFFFFFFF, R_ST, 1'b0,
                    64'h0, 64'h0, 1'b1};
        tbl[15] = '{LD, S8, 40'h1000, 64'h0, R_LD, 1'b1, A1, F, 1'b1};
        tbl[16] = '{ST, S16, 40'h1000, 64'h5555555555555555, R_ST, 1'b0,
                    64'h0, 64'h0, 1'b1};
        tbl[17] = '{OT, S8, 40'h1000, 64'h1234, R_ST, 1'b1,
                    64'h0, 64'h0, 1'b1};
        tbl[18] = '{LD, S8, 40'h1000, 64'h0, R_LD, 1'b1, A1, F, 1'b1};

        reset_n = 1'b0;
        l15.transducer_l15_val      = 1'b1;
        l15.transducer_l15_rqtype   = LD;
        l15.transducer_l15_nc       = 1'b0;
        l15.transducer_l15_size     = S8;
        l15.transducer_l15_address  = '0;
        l15.transducer_l15_data     = '0;
        l15.transducer_l15_l1rplway = '0;
        l15.transducer_l15_req_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_val", 128'(l15.l15_transducer_val), 128'(0));
        check("rst_ack", 128'(l15.l15_transducer_ack), 128'(0));
        check("rst_rt", 128'(l15.l15_transducer_returntype), 128'(0));
        check("rst_err", 128'(error), 128'(0));
        l15.transducer_l15_val = 1'b0;

        @(negedge clk);
        reset_n = 1'b1;
        wake();

        for (int i = 0; i < NV; i++) begin
            send(tbl[i].rq, tbl[i].sz, tbl[i].a, tbl[i].d);
            wait_resp(lat);
            check($sformatf("row%0d lat", i), 128'(lat), 128'(2));
            check($sformatf("row%0d rt", i),
                  128'(l15.l15_transducer_returntype), 128'(tbl[i].rt));
            if (tbl[i].chk) begin
                check($sformatf("row%0d d0", i),
                      128'(l15.l15_transducer_data_0), 128'(tbl[i].d0));
                check($sformatf("row%0d d1", i),
                      128'(l15.l15_transducer_data_1), 128'(tbl[i].d1));
            end
            check($sformatf("row%0d err", i), 128'(error), 128'(tbl[i].err));
            consume();
        end

        // Response held while unconsumed; a new request is not acked.
        send(LD, S8, 40'h1000, 64'h0);
        wait_resp(lat);
        l15.transducer_l15_val = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("hold_val", 128'(l15.l15_transducer_val), 128'(1));
            check("hold_d0", 128'(l15.l15_transducer_data_0), 128'(A1));
            check("hold_ack", 128'(l15.l15_transducer_ack), 128'(0));
        end
        l15.transducer_l15_val = 1'b0;
        consume();

        // Reset during a load response: dropped, wake resent, memory kept.
        send(LD, S8, 40'h1000, 64'h0);
        wait_resp(lat);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rr_val", 128'(l15.l15_transducer_val), 128'(0));
        check("rr_err", 128'(error), 128'(0));
        reset_n = 1'b1;
        wake();
        send(LD, S8, 40'h1000, 64'h0);
        wait_resp(lat);
        check("rr_lat", 128'(lat), 128'(2));
        check("rr_d0", 128'(l15.l15_transducer_data_0), 128'(A1));
        check("rr_d1", 128'(l15.l15_transducer_data_1), 128'(F));
        consume();

        // Reset while a store is in its access cycle: not written.
        send(ST, S8, 40'h1000, 64'hDEADBEEFDEADBEEF);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rs_val", 128'(l15.l15_transducer_val), 128'(0));
        reset_n = 1'b1;
        wake();
        send(LD, S8, 40'h1000, 64'h0);
        wait_resp(lat);
        check("rs_d0", 128'(l15.l15_transducer_data_0), 128'(A1));
        consume();

        // Stray req_ack with no response pending.
        check("sa_err0", 128'(error), 128'(0));
        l15.transducer_l15_req_ack = 1'b1;
        @(posedge clk);
        #1;
        l15.transducer_l15_req_ack = 1'b0;
        check("sa_err1", 128'(error), 128'(1));
        send(LD, S8, 40'h1008, 64'h0);
        wait_resp(lat);
        check("sa_lat", 128'(lat), 128'(2));
        check("sa_d1", 128'(l15.l15_transducer_data_1), 128'(F));
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
